fft_addr_gen: RTL and testbench

- Sequencing controller for the in-place radix-2 DIT FFT datapath.
- Drives the dual-port sample register file's top/bottom indices and write enable.
- Drives the twiddle index for the combinational butterfly that sits between register-file read and write-back.
- Issues one butterfly per clock across all log2(N) stages, then pulses done. Input data is already stored in bit-reversed order.

---
 rtl/fft_addr_gen.sv | 128 ++++++++++++
 tb/tb_fft_addr_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_gen.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT: one butterfly per
// clock over all LOG2N stages, with stall support and a one-cycle done pulse.
module fft_addr_gen #(
  parameter int LOG2N = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             hold,
  output logic [LOG2N-1:0] i_top,
  output logic [LOG2N-1:0] i_bot,
  output logic [LOG2N-2:0] tw_idx,
  output logic             write_en,
  output logic [3:0]       stage,
  output logic             busy,
  output logic             done
);

  localparam int TW_W = LOG2N - 1;
  localparam int NB   = 1 << TW_W;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state_p0;
  logic [TW_W-1:0] bfly_p0;

  logic            last_b;
  logic            last_s;
  logic [TW_W-1:0] bfly_nxt;
  logic [3:0]      stg_nxt;
  logic [LOG2N-1:0] top_nxt;
  logic [LOG2N-1:0] bot_nxt;
  logic [TW_W-1:0] tw_nxt;

  function automatic logic [LOG2N-1:0] half_of(input logic [3:0] s);
    return LOG2N'(1) << s;
  endfunction

  function automatic logic [LOG2N-1:0] pos_of(input logic [3:0] s, input logic [TW_W-1:0] b);
    return {1'b0, b} & (half_of(s) - LOG2N'(1));
  endfunction

  // Group index is shifted up one extra bit to leave room for the bottom half.
  function automatic logic [LOG2N-1:0] top_of(input logic [3:0] s, input logic [TW_W-1:0] b);
    logic [LOG2N-1:0] grp;
    grp = {1'b0, b} >> s;
    return (grp << (s + 4'd1)) | pos_of(s, b);
  endfunction

  function automatic logic [TW_W-1:0] tw_of(input logic [3:0] s, input logic [TW_W-1:0] b);
    logic [3:0] shamt;
    shamt = 4'(TW_W) - s;
    return TW_W'(pos_of(s, b) << shamt);
  endfunction

  always_comb begin
    last_b   = (bfly_p0 == TW_W'(NB - 1));
    last_s   = (stage == 4'(LOG2N - 1));
    bfly_nxt = bfly_p0 + TW_W'(1);
    stg_nxt  = last_b ? (stage + 4'd1) : stage;
    top_nxt  = top_of(stg_nxt, bfly_nxt);
    bot_nxt  = top_nxt + half_of(stg_nxt);
    tw_nxt   = tw_of(stg_nxt, bfly_nxt);
  end

  // A held edge drops write_en; the first unheld edge afterwards re-presents
  // the same pair instead of advancing, so every butterfly commits exactly once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_p0 <= IDLE;
      bfly_p0  <= '0;
      stage    <= '0;
      i_top    <= '0;
      i_bot    <= '0;
      tw_idx   <= '0;
      write_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          write_en <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          if (start) begin
            bfly_p0  <= '0;
            stage    <= '0;
            i_top    <= '0;
            i_bot    <= LOG2N'(1);
            tw_idx   <= '0;
            write_en <= 1'b1;
            busy     <= 1'b1;
            state_p0 <= RUN;
          end
        end
        RUN: begin
          if (hold) begin
            write_en <= 1'b0;
          end else if (!write_en) begin
            write_en <= 1'b1;
          end else if (last_b && last_s) begin
            write_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_p0 <= FINISH;
          end else begin
            bfly_p0  <= bfly_nxt;
            stage    <= stg_nxt;
            i_top    <= top_nxt;
            i_bot    <= bot_nxt;
            tw_idx   <= tw_nxt;
          end
        end
        FINISH: begin
          done     <= 1'b0;
          state_p0 <= IDLE;
        end
        default: begin
          write_en <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state_p0 <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen: expected butterfly pairs are queued at start
// and popped on every committed write (write_en high, hold low).
module tb_fft_addr_gen;

  localparam int LOG2N = 10;
  localparam int N     = 1 << LOG2N;
  localparam int NB    = N / 2;
  localparam int TOTAL = NB * LOG2N;

  logic             Clk   = 1'b0;
  logic             Reset = 1'b1;
  logic             start = 1'b0;
  logic             hold  = 1'b0;
  logic [LOG2N-1:0] i_top;
  logic [LOG2N-1:0] i_bot;
  logic [LOG2N-2:0] tw_idx;
  logic             write_en;
  logic [3:0]       stage;
  logic             busy;
  logic             done;

  always #5 Clk = ~Clk;

  fft_addr_gen #(.LOG2N(LOG2N)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .hold     (hold),
    .i_top    (i_top),
    .i_bot    (i_bot),
    .tw_idx   (tw_idx),
    .write_en (write_en),
    .stage    (stage),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [3:0]       stg;
    logic [LOG2N-1:0] top;
    logic [LOG2N-1:0] bot;
    logic [LOG2N-2:0] tw;
  } pair_t;

  pair_t exp_q[$];
  int    n_cmp     = 0;
  int    n_err     = 0;
  int    n_commit  = 0;
  int    cyc       = 0;
  int    start_cyc = 0;
  int    cov[N];
  int    cov_stage = 0;
  bit    cov_valid = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ordering: groups of 2*half samples, positions within a group inner.
  task automatic push_run();
    for (int s = 0; s < LOG2N; s++) begin
      int half;
      half = 1 << s;
      for (int j = 0; j < N; j += 2 * half) begin
        for (int k = 0; k < half; k++) begin
          pair_t p;
          p.stg = 4'(s);
          p.top = LOG2N'(j + k);
          p.bot = LOG2N'(j + k + half);
          p.tw  = (LOG2N-1)'(k * (NB / half));
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic cov_check();
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (cov[i] != 1) bad++;
      cov[i] = 0;
    end
    check_eq($sformatf("cover_s%0d", cov_stage), 64'(bad), 64'd0);
  endtask

  always @(negedge Clk) begin
    pair_t got;
    pair_t e;
    if (!Reset) begin
      for (int i = 0; i < N; i++) cov[i] = 0;
      cov_valid = 1'b0;
    end else begin
      if (write_en && !hold) begin
        got = {stage, i_top, i_bot, tw_idx};
        if (cov_valid && int'(stage) != cov_stage) cov_check();
        cov_valid = 1'b1;
        cov_stage = int'(stage);
        cov[i_top]++;
        cov[i_bot]++;
        if (n_commit == 1) begin
          check_eq("s0b1_top", 64'(i_top), 64'd2);
          check_eq("s0b1_bot", 64'(i_bot), 64'd3);
        end
        if (n_commit == NB + 1) begin
          check_eq("s1b1_top", 64'(i_top), 64'd1);
          check_eq("s1b1_bot", 64'(i_bot), 64'd3);
          check_eq("s1b1_tw", 64'(tw_idx), 64'd256);
        end
        if (n_commit == 2 * NB + 6) begin
          check_eq("s2b6_top", 64'(i_top), 64'd10);
          check_eq("s2b6_bot", 64'(i_bot), 64'd14);
          check_eq("s2b6_tw", 64'(tw_idx), 64'd256);
        end
        if (n_commit == 9 * NB + 5) begin
          check_eq("s9b5_top", 64'(i_top), 64'd5);
          check_eq("s9b5_bot", 64'(i_bot), 64'd517);
          check_eq("s9b5_tw", 64'(tw_idx), 64'd5);
        end
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("pair", 64'(got), 64'(e));
        end
        n_commit++;
      end
      if (done && cov_valid) begin
        cov_check();
        cov_valid = 1'b0;
      end
    end
  end

  // Called #1 after an edge while in IDLE; start is sampled on the next edge.
  task automatic start_run();
    n_commit = 0;
    push_run();
    start = 1'b1;
    @(posedge Clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input bit spam_start, input int exp_lat);
    bit seen;
    seen = 1'b0;
    for (int j = 0; j < TOTAL + 300; j++) begin
      if (spam_start) start = ((j % 7) == 3) && (j < TOTAL - 100);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge Clk);
      #1;
    end
    if (spam_start) start = 1'b0;
    if (!seen) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_lat"}, 64'(cyc - start_cyc), 64'(exp_lat));
      check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      check_eq({tag, "_we_at_done"}, 64'(write_en), 64'd0);
      check_eq({tag, "_commits"}, 64'(n_commit), 64'(TOTAL));
      check_eq({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
      @(posedge Clk);
      #1;
      check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_top"}, 64'(i_top), 64'd0);
    check_eq({tag, "_bot"}, 64'(i_bot), 64'd0);
    check_eq({tag, "_tw"}, 64'(tw_idx), 64'd0);
    check_eq({tag, "_stage"}, 64'(stage), 64'd0);
    check_eq({tag, "_we"}, 64'(write_en), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit found;

    #1 Reset = 1'b0;
    #2;
    check_zero("rst");
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Plain transform.
    start_run();
    check_eq("e0_we", 64'(write_en), 64'd1);
    check_eq("e0_busy", 64'(busy), 64'd1);
    check_eq("e0_stage", 64'(stage), 64'd0);
    check_eq("e0_top", 64'(i_top), 64'd0);
    check_eq("e0_bot", 64'(i_bot), 64'd1);
    check_eq("e0_tw", 64'(tw_idx), 64'd0);
    run_to_done("plain", 1'b0, TOTAL);

    // Three-cycle stall at stage 4, b=100.
    start_run();
    found = 1'b0;
    for (int j = 0; j < TOTAL; j++) begin
      if (stage == 4'd4 && i_top == LOG2N'(196) && write_en) begin
        found = 1'b1;
        break;
      end
      @(posedge Clk);
      #1;
    end
    check_eq("hold_find", 64'(found), 64'd1);
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(posedge Clk);
      #1;
      check_eq("hold_we", 64'(write_en), 64'd0);
      check_eq("hold_top", 64'(i_top), 64'd196);
      check_eq("hold_bot", 64'(i_bot), 64'd212);
      check_eq("hold_tw", 64'(tw_idx), 64'd128);
      check_eq("hold_stage", 64'(stage), 64'd4);
    end
    hold = 1'b0;
    @(posedge Clk);
    #1;
    check_eq("resume_we", 64'(write_en), 64'd1);
    check_eq("resume_top", 64'(i_top), 64'd196);
    run_to_done("hold", 1'b0, TOTAL + 4);

    // Asynchronous reset in stage 6, then restart.
    start_run();
    found = 1'b0;
    for (int j = 0; j < TOTAL; j++) begin
      if (stage == 4'd6) begin
        found = 1'b1;
        break;
      end
      @(posedge Clk);
      #1;
    end
    check_eq("rst6_find", 64'(found), 64'd1);
    #2 Reset = 1'b0;
    #1;
    check_zero("async_rst");
    exp_q.delete();
    @(posedge Clk);
    #3 Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("post_rst_we", 64'(write_en), 64'd0);
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    start_run();
    check_eq("restart_stage", 64'(stage), 64'd0);
    check_eq("restart_top", 64'(i_top), 64'd0);
    check_eq("restart_we", 64'(write_en), 64'd1);
    run_to_done("restart", 1'b0, TOTAL);

    // start pulsed repeatedly while running.
    start_run();
    run_to_done("start_spam", 1'b1, TOTAL);

    // start held high: second transform begins from IDLE after FINISH.
    n_commit = 0;
    push_run();
    start = 1'b1;
    @(posedge Clk);
    #1;
    start_cyc = cyc;
    run_to_done("held_first", 1'b0, TOTAL);
    check_eq("held_idle_busy", 64'(busy), 64'd0);
    check_eq("held_idle_we", 64'(write_en), 64'd0);
    n_commit = 0;
    push_run();
    @(posedge Clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    check_eq("held_second_busy", 64'(busy), 64'd1);
    check_eq("held_second_we", 64'(write_en), 64'd1);
    check_eq("held_second_stage", 64'(stage), 64'd0);
    check_eq("held_second_top", 64'(i_top), 64'd0);
    run_to_done("held_second", 1'b0, TOTAL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
